// File: rtl/des_pkg.sv
// des_pkg: DES key-schedule tables, default rotation mask, state encoding and permutation helpers.
package des_pkg;
    localparam int NUM_ROUNDS = 16;
    localparam logic [15:0] DEFAULT_SHIFT_MASK = 16'h7EFC;

    // Tables use the 1-based bit numbering of the DES standard (bit 1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE, ROUND} stateType;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        for (int i = 0; i < 56; i++)
            r[i+1] = k[PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        for (int i = 0; i < 48; i++)
            r[i+1] = cd[PC2_TAB[i]];
        return r;
    endfunction
endpackage

// File: rtl/des_key_rotator.sv
// des_key_rotator: rotates both 28-bit key halves left or right by 1 or 2 positions.
module des_key_rotator (
    input  logic [1:28] c,
    input  logic [1:28] d,
    input  logic        dir,
    input  logic        amt2,
    output logic [1:28] cRot,
    output logic [1:28] dRot
);
    assign cRot = dir ? (amt2 ? {c[27:28], c[1:26]} : {c[28], c[1:27]})
                      : (amt2 ? {c[3:28], c[1:2]} : {c[2:28], c[1]});
    assign dRot = dir ? (amt2 ? {d[27:28], d[1:26]} : {d[28], d[1:27]})
                      : (amt2 ? {d[3:28], d[1:2]} : {d[2:28], d[1]});
endmodule

// File: rtl/des_key_scheduler.sv
// des_key_scheduler: streams the 16 DES subkeys (forward or reversed) over valid/ready.
// Optional per-byte odd-parity key check enabled by DES_KEY_PARITY_CHECK_EN.
module des_key_scheduler
    import des_pkg::*;
#(
    parameter logic [15:0] SHIFT_MASK = DEFAULT_SHIFT_MASK,
    parameter int          ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               decrypt,
    input  logic [1:64]        key_in,
    output logic [1:48]        subkey,
    output logic               subkey_valid,
    input  logic               subkey_ready,
    output logic [ROUND_W-1:0] round_idx,
    output logic               busy,
    output logic               done,
    output logic               key_err
);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    stateType    state;
    logic [1:28] c, d, cSrc, dSrc, cRot, dRot;
    logic [1:56] keyPc1;
    logic        dec, dir, amt2, keyBad;

    assign keyPc1 = pc1(key_in);
    assign {cSrc, dSrc} = (state == IDLE) ? keyPc1 : {c, d};
    assign dir = (state == ROUND) & dec;
    // Decrypt walks the encrypt shift amounts backwards, undoing them with right rotates.
    assign amt2 = (state == IDLE) ? SHIFT_MASK[0]
                : dec ? SHIFT_MASK[LAST_ROUND - round_idx]
                : SHIFT_MASK[round_idx + 1'b1];
    assign subkey = pc2({c, d});

`ifdef DES_KEY_PARITY_CHECK_EN
    always_comb begin
        keyBad = 1'b0;
        for (int i = 0; i < 8; i++)
            keyBad = keyBad | ~(^key_in[8*i+1 +: 8]);
    end
`else
    assign keyBad = 1'b0;
`endif

    des_key_rotator rotator (
        .c    (cSrc),
        .d    (dSrc),
        .dir  (dir),
        .amt2 (amt2),
        .cRot (cRot),
        .dRot (dRot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            c            <= '0;
            d            <= '0;
            dec          <= 1'b0;
            round_idx    <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            key_err      <= 1'b0;
        end else begin
            done    <= 1'b0;
            key_err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (keyBad) begin
                        key_err <= 1'b1;
                    end else begin
                        dec          <= decrypt;
                        {c, d}       <= decrypt ? keyPc1 : {cRot, dRot};
                        round_idx    <= '0;
                        subkey_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ROUND;
                    end
                end
                ROUND: if (subkey_ready) begin
                    if (round_idx == LAST_ROUND) begin
                        state        <= IDLE;
                        subkey_valid <= 1'b0;
                        busy         <= 1'b0;
                        round_idx    <= '0;
                        done         <= 1'b1;
                    end else begin
                        {c, d}    <= {cRot, dRot};
                        round_idx <= round_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler: directed checks of the DES key schedule against known subkeys.
module tb_des_key_scheduler;
    logic        clk = 1'b0;
    logic        reset, start, decrypt, subkey_ready;
    logic [1:64] key_in;
    logic [1:48] subkey;
    logic        subkey_valid, busy, done, key_err;
    logic [3:0]  round_idx;
    int          checks = 0;
    int          errors = 0;
    int          cnt;
    logic        r;

    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] OTHER = 64'h0123456789ABCDEF;

    logic [47:0] expK [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done),
        .key_err      (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic startRun(input logic [63:0] k, input logic dec);
        key_in = k;
        decrypt = dec;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expectRounds(input logic dec, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            chk("valid", 64'(subkey_valid), 64'd1);
            chk("round_idx", 64'(round_idx), 64'(i));
            chk("subkey", 64'(subkey), 64'(dec ? expK[15-i] : expK[i]));
            @(negedge clk);
        end
    endtask

    task automatic checkDone();
        chk("done", 64'(done), 64'd1);
        chk("valid_after", 64'(subkey_valid), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("round_after", 64'(round_idx), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        decrypt = 1'b0;
        key_in = '0;
        subkey_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_round", 64'(round_idx), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_key_err", 64'(key_err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Encrypt with ready held high: 16 back-to-back subkeys.
        subkey_ready = 1'b1;
        startRun(KEY, 1'b0);
        chk("busy_run", 64'(busy), 64'd1);
        expectRounds(1'b0, 0, 15);
        checkDone();

        // Start issued on the done cycle must be accepted: decrypt run.
        startRun(KEY, 1'b1);
        expectRounds(1'b1, 0, 15);
        checkDone();
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);

        // Random backpressure.
        startRun(KEY, 1'b0);
        cnt = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (subkey_valid) begin
                chk("bp_round", 64'(round_idx), 64'(cnt));
                chk("bp_subkey", 64'(subkey), 64'(expK[cnt % 16]));
                r = 1'($urandom_range(0, 1));
                subkey_ready = r;
                if (r) cnt++;
            end
            @(negedge clk);
        end
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_transfers", 64'(cnt), 64'd16);
        subkey_ready = 1'b1;
        @(negedge clk);

        // Start with a different key during round 5 is ignored.
        startRun(KEY, 1'b0);
        expectRounds(1'b0, 0, 4);
        key_in = OTHER;
        decrypt = 1'b1;
        start = 1'b1;
        expectRounds(1'b0, 5, 5);
        start = 1'b0;
        expectRounds(1'b0, 6, 15);
        checkDone();
        @(negedge clk);

        // Reset at round 7 abandons the schedule without a done pulse.
        startRun(KEY, 1'b0);
        expectRounds(1'b0, 0, 6);
        chk("pre_rst_round", 64'(round_idx), 64'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", 64'(subkey_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_round", 64'(round_idx), 64'd0);
        chk("mid_rst_subkey", 64'(subkey), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("post_rst_done", 64'(done), 64'd0);
        startRun(KEY, 1'b0);
        expectRounds(1'b0, 0, 15);
        checkDone();
        @(negedge clk);

`ifdef DES_KEY_PARITY_CHECK_EN
        startRun(64'h0, 1'b0);
        chk("par_key_err", 64'(key_err), 64'd1);
        chk("par_busy", 64'(busy), 64'd0);
        chk("par_valid", 64'(subkey_valid), 64'd0);
        @(negedge clk);
        chk("par_key_err_pulse", 64'(key_err), 64'd0);
        chk("par_valid2", 64'(subkey_valid), 64'd0);
        startRun(KEY, 1'b0);
        chk("par_ok_key_err", 64'(key_err), 64'd0);
        expectRounds(1'b0, 0, 15);
        checkDone();
`else
        // All-zero key has even parity but is accepted; every subkey is zero.
        startRun(64'h0, 1'b0);
        chk("nopar_key_err", 64'(key_err), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk("zero_valid", 64'(subkey_valid), 64'd1);
            chk("zero_round", 64'(round_idx), 64'(i));
            chk("zero_subkey", 64'(subkey), 64'd0);
            @(negedge clk);
        end
        checkDone();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
